// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong score controller: match states,
// winner codes, the blank digit code and two-digit BCD arithmetic.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE    = 2'b00;
    localparam logic [1:0] WIN_L       = 2'b01;
    localparam logic [1:0] WIN_R       = 2'b10;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Ones wraps 9 -> 0 and carries into tens; scores never reach 100.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t to_bcd(input int unsigned v);
        bcd2_t r;
        r.tens = 4'(v / 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Control pulses in, digit codes and match status out, for score_ctrl.
interface score_ctrl_if;
    logic       start;
    logic       clear;
    logic       point_l;
    logic       point_r;
    logic [3:0] l_tens;
    logic [3:0] l_ones;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       playing;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, clear, point_l, point_r,
        input  l_tens, l_ones, r_tens, r_ones, playing, game_over, winner
    );

    modport slave (
        input  start, clear, point_l, point_r,
        output l_tens, l_ones, r_tens, r_ones, playing, game_over, winner
    );
endinterface

// File: rtl/score_ctrl_bcd_counter2.sv
// Two-digit BCD point counter, one instance per player.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    bcd2_t r_score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (clr) begin
            r_score <= '0;
        end else if (inc) begin
            r_score <= bcd_inc(r_score);
        end
    end

    assign tens = r_score.tens;
    assign ones = r_score.ones;

endmodule

// File: rtl/score_ctrl.sv
// Pong match controller: BCD scores, idle/play/over FSM, leading-zero blanking.
// Define SCORE_BLINK_EN to blink the winner's digits while the match is over.
module score_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 7,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic         clk,
    input  logic         reset,
    score_ctrl_if.slave  bus
);

    localparam bcd2_t WIN_M1 = to_bcd(WIN_SCORE - 1);

    // Out-of-range parameter sets elaborate this marker block.
    if (BLINK_DIV < 2 || WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_bad_params
    end

    state_t     r_state;
    logic [1:0] r_winner;
    logic [3:0] r_l_tens, r_l_ones, r_r_tens, r_r_ones;
    logic       r_playing, r_game_over;

    logic       w_scores_clr, w_pts_ok, w_inc_l, w_inc_r, w_win_l, w_win_r;
    logic [3:0] w_l_tens, w_l_ones, w_r_tens, w_r_ones;
    bcd2_t      w_l_cur, w_r_cur, w_l_nxt, w_r_nxt;
    state_t     w_state_nxt;
    logic [1:0] w_winner_nxt;
    logic       w_show_l, w_show_r;

    // Start only restarts outside PLAY; start and clear both mask points.
    assign w_scores_clr = bus.clear | (bus.start & (r_state != PLAY));
    assign w_pts_ok     = (r_state == PLAY) & ~bus.clear & ~bus.start;
    assign w_inc_l      = w_pts_ok & bus.point_l & ~bus.point_r;
    assign w_inc_r      = w_pts_ok & bus.point_r & ~bus.point_l;

    bcd_counter2 u_cnt_l (
        .clk   (clk),
        .reset (reset),
        .clr   (w_scores_clr),
        .inc   (w_inc_l),
        .tens  (w_l_tens),
        .ones  (w_l_ones)
    );

    bcd_counter2 u_cnt_r (
        .clk   (clk),
        .reset (reset),
        .clr   (w_scores_clr),
        .inc   (w_inc_r),
        .tens  (w_r_tens),
        .ones  (w_r_ones)
    );

    assign w_l_cur = '{tens: w_l_tens, ones: w_l_ones};
    assign w_r_cur = '{tens: w_r_tens, ones: w_r_ones};
    assign w_win_l = w_inc_l & (w_l_cur == WIN_M1);
    assign w_win_r = w_inc_r & (w_r_cur == WIN_M1);

    // Mirror the counters' next value so display registers update on the same edge.
    always_comb begin
        w_l_nxt = w_l_cur;
        w_r_nxt = w_r_cur;
        if (w_scores_clr) begin
            w_l_nxt = '0;
            w_r_nxt = '0;
        end else begin
            if (w_inc_l) w_l_nxt = bcd_inc(w_l_cur);
            if (w_inc_r) w_r_nxt = bcd_inc(w_r_cur);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        if (bus.clear) begin
            w_state_nxt  = IDLE;
            w_winner_nxt = WIN_NONE;
        end else if (bus.start && r_state != PLAY) begin
            w_state_nxt  = PLAY;
            w_winner_nxt = WIN_NONE;
        end else if (w_win_l) begin
            w_state_nxt  = OVER;
            w_winner_nxt = WIN_L;
        end else if (w_win_r) begin
            w_state_nxt  = OVER;
            w_winner_nxt = WIN_R;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic               r_blink_on, w_blink_on_nxt;

    // Counter restarts with the digits visible on every OVER entry.
    always_comb begin
        w_blink_cnt_nxt = '0;
        w_blink_on_nxt  = 1'b1;
        if (r_state == OVER && w_state_nxt == OVER) begin
            if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                w_blink_on_nxt = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
                w_blink_on_nxt  = r_blink_on;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end

    assign w_show_l = ~((w_state_nxt == OVER) & (w_winner_nxt == WIN_L) & ~w_blink_on_nxt);
    assign w_show_r = ~((w_state_nxt == OVER) & (w_winner_nxt == WIN_R) & ~w_blink_on_nxt);
`else
    assign w_show_l = 1'b1;
    assign w_show_r = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_winner    <= WIN_NONE;
            r_l_tens    <= BLANK_DIGIT;
            r_l_ones    <= 4'd0;
            r_r_tens    <= BLANK_DIGIT;
            r_r_ones    <= 4'd0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_l_tens    <= (!w_show_l || w_l_nxt.tens == 4'd0) ? BLANK_DIGIT : w_l_nxt.tens;
            r_l_ones    <= w_show_l ? w_l_nxt.ones : BLANK_DIGIT;
            r_r_tens    <= (!w_show_r || w_r_nxt.tens == 4'd0) ? BLANK_DIGIT : w_r_nxt.tens;
            r_r_ones    <= w_show_r ? w_r_nxt.ones : BLANK_DIGIT;
            r_playing   <= (w_state_nxt == PLAY);
            r_game_over <= (w_state_nxt == OVER);
        end
    end

    assign bus.l_tens    = r_l_tens;
    assign bus.l_ones    = r_l_ones;
    assign bus.r_tens    = r_r_tens;
    assign bus.r_ones    = r_r_ones;
    assign bus.playing   = r_playing;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl built with WIN_SCORE=12, BLINK_DIV=4.
module tb_score_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic blink_en;

    score_ctrl_if bus ();

    score_ctrl #(.WIN_SCORE(12), .BLINK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic c, input logic pl, input logic pr);
        bus.start   = s;
        bus.clear   = c;
        bus.point_l = pl;
        bus.point_r = pr;
        tick();
        bus.start   = 1'b0;
        bus.clear   = 1'b0;
        bus.point_l = 1'b0;
        bus.point_r = 1'b0;
    endtask

    function automatic logic [15:0] disp();
        return {bus.l_tens, bus.l_ones, bus.r_tens, bus.r_ones};
    endfunction

    function automatic logic [3:0] status();
        return {bus.playing, bus.game_over, bus.winner};
    endfunction

    initial begin
`ifdef SCORE_BLINK_EN
        blink_en = 1'b1;
`else
        blink_en = 1'b0;
`endif
        bus.start = 1'b0; bus.clear = 1'b0; bus.point_l = 1'b0; bus.point_r = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("reset_disp", 32'(disp()), 32'hF0F0);
        check("reset_stat", 32'(status()), 32'h0);
        reset = 1'b0;

        pulse(0, 0, 1, 0);
        check("idle_point", 32'(disp()), 32'hF0F0);
        check("idle_stat", 32'(status()), 32'h0);

        pulse(1, 0, 0, 0);
        check("start_stat", 32'(status()), 32'b1000);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        check("score_3_1", 32'(disp()), 32'hF3F1);
        check("play_stat", 32'(status()), 32'b1000);

        pulse(0, 0, 1, 1);
        check("dead_ball", 32'(disp()), 32'hF3F1);
        pulse(1, 0, 0, 0);
        check("start_in_play", 32'(disp()), 32'hF3F1);
        check("start_in_play_st", 32'(status()), 32'b1000);

        for (int i = 0; i < 7; i++) pulse(0, 0, 1, 0);
        check("carry_10", 32'(disp()), 32'h10F1);
        pulse(0, 0, 1, 0);
        check("score_11", 32'(disp()), 32'h11F1);
        check("no_win_11", 32'(status()), 32'b1000);
        pulse(0, 0, 1, 0);
        check("win_l_disp", 32'(disp()), 32'h12F1);
        check("win_l_stat", 32'(status()), 32'b0101);

        pulse(0, 0, 1, 0);
        check("over_point", 32'(disp()), 32'h12F1);
        check("over_point_st", 32'(status()), 32'b0101);
        tick(); tick();
        check("blink_l_vis", 32'(disp()), 32'h12F1);
        tick();
        check("blink_l_off", 32'(disp()), blink_en ? 32'hFFF1 : 32'h12F1);
        for (int i = 0; i < 4; i++) tick();
        check("blink_l_on", 32'(disp()), 32'h12F1);

        pulse(1, 0, 0, 0);
        check("restart_disp", 32'(disp()), 32'hF0F0);
        check("restart_stat", 32'(status()), 32'b1000);

        for (int i = 0; i < 4; i++) pulse(0, 0, 1, 0);
        for (int i = 0; i < 2; i++) pulse(0, 0, 0, 1);
        check("score_4_2", 32'(disp()), 32'hF4F2);
        pulse(0, 1, 0, 0);
        check("clear_disp", 32'(disp()), 32'hF0F0);
        check("clear_stat", 32'(status()), 32'h0);

        pulse(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) pulse(0, 0, 0, 1);
        check("win_r_disp", 32'(disp()), 32'hF012);
        check("win_r_stat", 32'(status()), 32'b0110);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("blink_r_%0d", k), 32'(disp()),
                  (blink_en && k >= 4 && k <= 7) ? 32'hF0FF : 32'hF012);
        end

        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("pre_reset", 32'(disp()), 32'hF2F0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_disp", 32'(disp()), 32'hF0F0);
        check("async_reset_stat", 32'(status()), 32'h0);
        reset = 1'b0;
        pulse(0, 0, 1, 0);
        check("post_reset_point", 32'(disp()), 32'hF0F0);
        check("post_reset_stat", 32'(status()), 32'h0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        check("post_reset_play", 32'(disp()), 32'hF1F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
